// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: digit/operator/equals handshake from the keypad scanner to the calculator controller
interface keypad_scanner_if;
  logic [3:0] keypad_input;
  logic       read_input;
  logic [2:0] operator_input;
  logic       equal_input;
  logic       clear_pulse;
  modport master(output keypad_input, read_input, operator_input, equal_input, clear_pulse);
  modport slave(input keypad_input, read_input, operator_input, equal_input, clear_pulse);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix scan, debounce and key decode; KEYPAD_REPEAT_EN adds digit auto-repeat
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_SCANS = 64
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic [3:0]       col_n,
  output logic [3:0]       row_n,
  keypad_scanner_if.master kp
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_CNT + 1);
  localparam int RW = $clog2(REPEAT_SCANS + 1);
`ifdef KEYPAD_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif
  localparam logic [1:0] K_NONE = 2'd0, K_VALID = 2'd1, K_MULTI = 2'd2;
  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;
  logic [3:0] col_s1_q, col_s1_d, col_s2_q, col_s2_d, row_n_q, row_n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] row_q, row_d, acc_n_q, acc_n_d, seen, kind;
  logic [3:0] acc_idx_q, acc_idx_d, idx, key_q, key_d, digit;
  logic [5:0] code_q, code_d, prev_q, prev_d;
  logic eval_q, eval_d, last, hit, stable, act, is_digit, op_key;
  logic [SW-1:0] stab_q, stab_d, stab_n;
  logic [RW-1:0] rep_q, rep_d;
  state_t st_q, st_d;
  logic [3:0] keypad_q, keypad_d;
  logic [2:0] op_latch_q, op_latch_d, operator_q, operator_d;
  logic read_q, read_d, equal_q, equal_d, clear_q, clear_d;
  // row rotation, column synchronizer and assembly of one code per full scan
  always_comb begin
    col_s1_d = col_n;
    col_s2_d = col_s1_q;
    last = cnt_q == CW'(SCAN_DIV - 1);
    cnt_d = last ? '0 : cnt_q + 1'b1;
    row_d = last ? row_q + 2'd1 : row_q;
    row_n_d = last ? {row_n_q[2:0], row_n_q[3]} : row_n_q;
    seen = acc_n_q;
    idx = acc_idx_q;
    for (int i = 0; i < 4; i++)
      if (!col_s2_q[i]) begin
        seen = (seen == 2'd2) ? 2'd2 : seen + 2'd1;
        idx = {row_q, 2'(i)};
      end
    eval_d = last && row_q == 2'd3;
    acc_n_d = eval_d ? 2'd0 : last ? seen : acc_n_q;
    acc_idx_d = last ? idx : acc_idx_q;
    code_d = !eval_d ? code_q : (seen == 2'd0) ? {K_NONE, 4'd0} : (seen == 2'd1) ? {K_VALID, idx} : {K_MULTI, 4'd0};
  end
  // stability counter, press FSM and key actions; the FSM advances only on the cycle after a scan completes
  always_comb begin
    kind = code_q[5:4];
    hit = kind == K_VALID && code_q[3:0] == key_q;
    stab_n = (kind == K_MULTI) ? '0 : (code_q != prev_q) ? SW'(1) : (stab_q == SW'(DEBOUNCE_CNT)) ? stab_q : stab_q + 1'b1;
    stable = stab_n == SW'(DEBOUNCE_CNT);
    stab_d = eval_q ? stab_n : stab_q;
    prev_d = eval_q ? code_q : prev_q;
    is_digit = key_q[1:0] != 2'd3 && key_q != 4'd12 && key_q != 4'd14;
    digit = (key_q == 4'd13) ? 4'd0 : 4'(key_q[3:2]) * 4'd3 + 4'(key_q[1:0]) + 4'd1;
    st_d = st_q;
    key_d = key_q;
    rep_d = rep_q;
    act = 1'b0;
    if (eval_q)
      case (st_q)
        IDLE: if (kind == K_VALID) begin st_d = CONFIRM; key_d = code_q[3:0]; end
        CONFIRM: begin
          st_d = !hit ? IDLE : stable ? HELD : CONFIRM;
          act = hit && stable;
          rep_d = '0;
        end
        HELD: begin
          st_d = hit ? HELD : RELEASE;
          act = REP_EN && hit && is_digit && rep_q == RW'(REPEAT_SCANS - 1);
          rep_d = (REP_EN && hit && is_digit && rep_q != RW'(REPEAT_SCANS - 1)) ? rep_q + 1'b1 : '0;
        end
        RELEASE: st_d = hit ? HELD : (kind == K_NONE && stable) ? IDLE : RELEASE;
        default: st_d = IDLE;
      endcase
    op_key = act && key_q[1:0] == 2'd3 && key_q[3:2] != 2'd3;
    read_d = act && is_digit;
    clear_d = act && key_q == 4'd12;
    keypad_d = read_d ? digit : clear_d ? 4'd0 : keypad_q;
    equal_d = (read_d || clear_d) ? 1'b0 : (act && key_q == 4'd14) ? 1'b1 : equal_q;
    op_latch_d = (clear_d || (read_d && equal_q)) ? 3'd0 : op_key ? 3'(key_q[3:2]) + 3'd2 : op_latch_q;
    operator_d = (act && key_q == 4'd15) ? 3'd1 : op_latch_d;
  end
  // all state and registered outputs
  always_ff @(posedge clk or negedge nRST)
    if (!nRST) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
      row_n_q <= 4'b1110;
      cnt_q <= '0;
      row_q <= 2'd0;
      acc_n_q <= 2'd0;
      acc_idx_q <= 4'd0;
      code_q <= 6'd0;
      prev_q <= 6'd0;
      eval_q <= 1'b0;
      stab_q <= '0;
      rep_q <= '0;
      st_q <= IDLE;
      key_q <= 4'd0;
      keypad_q <= 4'd0;
      read_q <= 1'b0;
      op_latch_q <= 3'd0;
      operator_q <= 3'd0;
      equal_q <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      col_s1_q <= col_s1_d;
      col_s2_q <= col_s2_d;
      row_n_q <= row_n_d;
      cnt_q <= cnt_d;
      row_q <= row_d;
      acc_n_q <= acc_n_d;
      acc_idx_q <= acc_idx_d;
      code_q <= code_d;
      prev_q <= prev_d;
      eval_q <= eval_d;
      stab_q <= stab_d;
      rep_q <= rep_d;
      st_q <= st_d;
      key_q <= key_d;
      keypad_q <= keypad_d;
      read_q <= read_d;
      op_latch_q <= op_latch_d;
      operator_q <= operator_d;
      equal_q <= equal_d;
      clear_q <= clear_d;
    end
  assign row_n = row_n_q;
  assign kp.keypad_input = keypad_q;
  assign kp.read_input = read_q;
  assign kp.operator_input = operator_q;
  assign kp.equal_input = equal_q;
  assign kp.clear_pulse = clear_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model driving the scanner, checked against a key-level calculator input model
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic nRST = 1'b1;
  logic [3:0] col_n, row_n;
  logic [3:0] glitch_n = 4'hF;
  logic [15:0] pressed = '0;
  int cyc = 0, t0 = 0, t_rd = 0, n_cmp = 0, n_fail = 0;
  int ev[$];
  logic rd_eq = 1'b0, rd_prev = 1'b0, cl_prev = 1'b0, ng_prev = 1'b0;
  logic [2:0] rd_op = 3'd0;
  logic [2:0] m_op = 3'd0;
  logic m_eq = 1'b0;
  logic [3:0] m_kp = 4'd0;
  string keymap = "123A456B789C*0#D";

  keypad_scanner_if kp();
  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(2), .REPEAT_SCANS(64)) dut (
    .clk(clk), .nRST(nRST), .col_n(col_n), .row_n(row_n), .kp(kp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // matrix: a closed key pulls its column low while its row is driven low
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row_n[r])
        for (int c = 0; c < 4; c++)
          if (pressed[4*r+c]) col_n[c] = 1'b0;
    col_n = col_n & glitch_n;
  end

  // event log: digits 0-9, clear 20, negate 21, any pulse longer than one cycle 99
  always @(negedge clk)
    if (!nRST) begin
      rd_prev = 1'b0; cl_prev = 1'b0; ng_prev = 1'b0;
    end else begin
      if (kp.read_input) begin
        ev.push_back(rd_prev ? 99 : int'(kp.keypad_input));
        t_rd = cyc; rd_eq = kp.equal_input; rd_op = kp.operator_input;
      end
      if (kp.clear_pulse) ev.push_back(cl_prev ? 99 : 20);
      if (kp.operator_input == 3'd1) ev.push_back(ng_prev ? 99 : 21);
      rd_prev = kp.read_input; cl_prev = kp.clear_pulse; ng_prev = kp.operator_input == 3'd1;
    end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // calculator-input semantics of one accepted key press; returns the expected pulse event or -1
  function automatic int model(input int k);
    byte c;
    c = keymap[k];
    case (c)
      "A": m_op = 3'd2;
      "B": m_op = 3'd3;
      "C": m_op = 3'd4;
      "D": return 21;
      "#": m_eq = 1'b1;
      "*": begin m_op = 3'd0; m_eq = 1'b0; m_kp = 4'd0; return 20; end
      default: begin
        m_kp = 4'(c - 8'd48);
        if (m_eq) begin m_eq = 1'b0; m_op = 3'd0; end
        return int'(c) - 48;
      end
    endcase
    return -1;
  endfunction

  function automatic int first_ev();
    return (ev.size() > 0) ? ev[0] : -1;
  endfunction

  task automatic hold_key(input int k, input int hold, input int gap);
    ev.delete();
    pressed[k] = 1'b1;
    t0 = cyc;
    tick(hold * 16);
    pressed[k] = 1'b0;
    tick(gap * 16);
  endtask

  task automatic test_reset;
    logic [3:0] exp_row;
    nRST = 1'b0;
    tick(3);
    n_cmp++; if (row_n !== 4'b1110) begin n_fail++; $display("FAIL reset_row_n: got %b want 1110", row_n); end
    n_cmp++; if (kp.keypad_input !== 4'd0) begin n_fail++; $display("FAIL reset_keypad: got %0d want 0", kp.keypad_input); end
    n_cmp++; if (kp.read_input !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b want 0", kp.read_input); end
    n_cmp++; if (kp.operator_input !== 3'd0) begin n_fail++; $display("FAIL reset_operator: got %0d want 0", kp.operator_input); end
    n_cmp++; if (kp.equal_input !== 1'b0) begin n_fail++; $display("FAIL reset_equal: got %b want 0", kp.equal_input); end
    n_cmp++; if (kp.clear_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_clear: got %b want 0", kp.clear_pulse); end
    nRST = 1'b1;
    for (int k = 0; k < 16; k++) begin
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      n_cmp++; if (row_n !== exp_row) begin n_fail++; $display("FAIL row_rotation[%0d]: got %b want %b", k, row_n, exp_row); end
      tick(1);
    end
  endtask

  task automatic test_single_press;
    int e;
    hold_key(8, 6, 5);
    e = model(8);
    n_cmp++; if (ev.size() != 1 || first_ev() != e) begin n_fail++; $display("FAIL press7_events: got %0d events first %0d want 1 event %0d", ev.size(), first_ev(), e); end
    n_cmp++; if (t_rd - t0 > 48 || t_rd - t0 < 16) begin n_fail++; $display("FAIL press7_latency: got %0d cycles want 16..48", t_rd - t0); end
    n_cmp++; if (kp.keypad_input !== m_kp) begin n_fail++; $display("FAIL press7_keypad: got %0d want %0d", kp.keypad_input, m_kp); end
  endtask

  task automatic test_operators;
    int keys[3] = '{3, 15, 7};
    int e;
    foreach (keys[i]) begin
      hold_key(keys[i], 4, 5);
      e = model(keys[i]);
      n_cmp++; if (ev.size() != (e < 0 ? 0 : 1) || (e >= 0 && first_ev() != e)) begin n_fail++; $display("FAIL op_events key %0d: got %0d events first %0d want %0d", keys[i], ev.size(), first_ev(), e); end
      n_cmp++; if (kp.operator_input !== m_op) begin n_fail++; $display("FAIL op_level key %0d: got %0d want %0d", keys[i], kp.operator_input, m_op); end
    end
  endtask

  task automatic test_equals;
    int keys[4] = '{0, 11, 1, 14};
    int e;
    foreach (keys[i]) begin
      hold_key(keys[i], 4, 5);
      e = model(keys[i]);
      n_cmp++; if (ev.size() != (e < 0 ? 0 : 1) || (e >= 0 && first_ev() != e)) begin n_fail++; $display("FAIL eq_events key %0d: got %0d events first %0d want %0d", keys[i], ev.size(), first_ev(), e); end
    end
    n_cmp++; if (kp.operator_input !== 3'd4 || kp.equal_input !== 1'b1) begin n_fail++; $display("FAIL eq_held: got op %0d eq %b want op 4 eq 1", kp.operator_input, kp.equal_input); end
    hold_key(5, 4, 5);
    e = model(5);
    n_cmp++; if (ev.size() != 1 || first_ev() != e) begin n_fail++; $display("FAIL eq_newcalc_events: got %0d events first %0d want 1 event %0d", ev.size(), first_ev(), e); end
    n_cmp++; if (rd_eq !== 1'b0 || rd_op !== 3'd0) begin n_fail++; $display("FAIL eq_newcalc_same_cycle: got eq %b op %0d want eq 0 op 0", rd_eq, rd_op); end
  endtask

  task automatic test_multi_key;
    int e;
    ev.delete();
    pressed[4] = 1'b1; pressed[5] = 1'b1;
    tick(5 * 16);
    n_cmp++; if (ev.size() != 0) begin n_fail++; $display("FAIL multi_no_action: got %0d events want 0", ev.size()); end
    pressed[5] = 1'b0;
    e = model(4);
    tick(4 * 16);
    n_cmp++; if (ev.size() != 1 || first_ev() != e) begin n_fail++; $display("FAIL multi_then_4: got %0d events first %0d want 1 event %0d", ev.size(), first_ev(), e); end
    pressed[4] = 1'b0;
    tick(5 * 16);
    n_cmp++; if (ev.size() != 1) begin n_fail++; $display("FAIL multi_release: got %0d events want 1", ev.size()); end
  endtask

  task automatic test_glitch_clear;
    int e;
    logic [3:0] one;
    ev.delete();
    for (int i = 0; i < 12; i++) begin
      one = 4'b0001 << $urandom_range(0, 3);
      glitch_n = ~one;
      tick(1);
      glitch_n = 4'hF;
      tick(9);
    end
    tick(3 * 16);
    n_cmp++; if (ev.size() != 0) begin n_fail++; $display("FAIL glitch_no_action: got %0d events want 0", ev.size()); end
    hold_key(12, 4, 5);
    e = model(12);
    n_cmp++; if (ev.size() != 1 || first_ev() != e) begin n_fail++; $display("FAIL clear_events: got %0d events first %0d want 1 event %0d", ev.size(), first_ev(), e); end
    n_cmp++; if (kp.operator_input !== 3'd0 || kp.equal_input !== 1'b0 || kp.keypad_input !== 4'd0) begin n_fail++; $display("FAIL clear_levels: got op %0d eq %b kp %0d want 0 0 0", kp.operator_input, kp.equal_input, kp.keypad_input); end
  endtask

  task automatic test_reset_midpress;
    int e;
    ev.delete();
    pressed[10] = 1'b1;
    tick(4 * 16);
    e = model(10);
    n_cmp++; if (ev.size() != 1 || first_ev() != e) begin n_fail++; $display("FAIL pre_reset_9: got %0d events first %0d want 1 event %0d", ev.size(), first_ev(), e); end
    nRST = 1'b0;
    tick(2);
    m_op = 3'd0; m_eq = 1'b0; m_kp = 4'd0;
    n_cmp++; if (row_n !== 4'b1110 || kp.keypad_input !== 4'd0 || kp.operator_input !== 3'd0 || kp.equal_input !== 1'b0 || kp.read_input !== 1'b0 || kp.clear_pulse !== 1'b0) begin n_fail++; $display("FAIL midpress_reset_values: got row %b kp %0d op %0d eq %b rd %b clr %b", row_n, kp.keypad_input, kp.operator_input, kp.equal_input, kp.read_input, kp.clear_pulse); end
    ev.delete();
    nRST = 1'b1;
    t0 = cyc;
    tick(5 * 16);
    e = model(10);
    n_cmp++; if (ev.size() != 1 || first_ev() != e) begin n_fail++; $display("FAIL post_reset_9: got %0d events first %0d want 1 event %0d", ev.size(), first_ev(), e); end
    n_cmp++; if (t_rd - t0 < 32) begin n_fail++; $display("FAIL post_reset_debounce: got %0d cycles want >= 32", t_rd - t0); end
    pressed[10] = 1'b0;
    tick(5 * 16);
    n_cmp++; if (ev.size() != 1) begin n_fail++; $display("FAIL post_reset_release: got %0d events want 1", ev.size()); end
  endtask

  task automatic test_random;
    int k, e;
    for (int i = 0; i < 16; i++) begin
      k = $urandom_range(0, 15);
      tick($urandom_range(0, 15));
      hold_key(k, $urandom_range(3, 6), $urandom_range(4, 5));
      e = model(k);
      n_cmp++; if (ev.size() != (e < 0 ? 0 : 1) || (e >= 0 && first_ev() != e)) begin n_fail++; $display("FAIL rand_events[%0d] key %0d: got %0d events first %0d want %0d", i, k, ev.size(), first_ev(), e); end
      n_cmp++; if (kp.operator_input !== m_op) begin n_fail++; $display("FAIL rand_operator[%0d] key %0d: got %0d want %0d", i, k, kp.operator_input, m_op); end
      n_cmp++; if (kp.equal_input !== m_eq) begin n_fail++; $display("FAIL rand_equal[%0d] key %0d: got %b want %b", i, k, kp.equal_input, m_eq); end
      n_cmp++; if (kp.keypad_input !== m_kp) begin n_fail++; $display("FAIL rand_keypad[%0d] key %0d: got %0d want %0d", i, k, kp.keypad_input, m_kp); end
    end
  endtask

  initial begin
    test_reset;
    test_single_press;
    test_operators;
    test_equals;
    test_multi_key;
    test_glitch_clear;
    test_reset_midpress;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
